// File: rtl/sha256_msg_ctrl_pkg.sv
// Shared constants and state encoding for the SHA-256 message sequencer.
package sha256_msg_ctrl_pkg;

  // FIPS 180-4 initial hash value, H0 in the top word.
  localparam logic [255:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHAIN = 3'd3,
    ST_OUT   = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

endpackage

// File: rtl/sha256_msg_ctrl.sv
// Message-level sequencer for the sha256_block round core: takes padded
// 512-bit blocks, launches the core, chains intermediate hashes and hands
// out the final digest.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for the first block of a message, chain = H_INIT
// START  | one-cycle load pulse to the core with the registered block
// RUN    | core working; watchdog counts until core_done
// CHAIN  | block done, not last; waiting for the next block
// OUT    | digest presented, held until the consumer takes it
// FAULT  | core never answered; sticky until reset
module sha256_msg_ctrl
  import sha256_msg_ctrl_pkg::*;
#(
  parameter int COUNT_W  = 32,
  parameter int WDOG_MAX = 80
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_s_valid,
  output logic               o_s_ready,
  input  logic [511:0]       i_s_block,
  input  logic               i_s_last,
  output logic               o_m_valid,
  input  logic               i_m_ready,
  output logic [255:0]       o_m_digest,
  output logic [255:0]       o_core_H_in,
  output logic [511:0]       o_core_M_in,
  output logic               o_core_start,
  input  logic [255:0]       i_core_H_out,
  input  logic               i_core_done,
  output logic               o_busy,
  output logic               o_fault,
  output logic [COUNT_W-1:0] o_blocks_done
);

  localparam int                WDOG_W  = $clog2(WDOG_MAX + 1);
  localparam logic [WDOG_W-1:0] WDOG_TC = WDOG_W'(WDOG_MAX);

  state_t               r_state;
  logic [511:0]         r_block;
  logic                 r_last;
  logic [255:0]         r_chain;
  logic [255:0]         r_digest;
  logic [COUNT_W-1:0]   r_blocks_done;
  logic [WDOG_W-1:0]    r_wdog;
  logic                 r_s_ready;
  logic                 r_m_valid;
  logic                 r_core_start;
  logic                 r_fault;

  logic                 w_accept;
  logic [WDOG_W-1:0]    w_wdog_nxt;

  assign w_accept   = i_s_valid && r_s_ready;
  assign w_wdog_nxt = r_wdog + 1'b1;

  // Sequencer FSM with registered handshake/control outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_block       <= '0;
      r_last        <= 1'b0;
      r_chain       <= H_INIT;
      r_digest      <= '0;
      r_blocks_done <= '0;
      r_wdog        <= '0;
      r_s_ready     <= 1'b0;
      r_m_valid     <= 1'b0;
      r_core_start  <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // Ready rises the cycle after reset; afterwards it is already 1.
          r_s_ready <= 1'b1;
          if (w_accept) begin
            r_block       <= i_s_block;
            r_last        <= i_s_last;
            r_blocks_done <= '0;
            r_s_ready     <= 1'b0;
            r_core_start  <= 1'b1;
            r_state       <= ST_START;
          end
        end
        ST_START: begin
          r_core_start <= 1'b0;
          r_wdog       <= '0;
          r_state      <= ST_RUN;
        end
        ST_RUN: begin
          r_wdog <= w_wdog_nxt;
          if (i_core_done) begin
            // core_H_out is only valid this cycle, so this is the one capture.
            r_chain <= i_core_H_out;
            if (r_blocks_done != '1)
              r_blocks_done <= r_blocks_done + 1'b1;
            if (r_last) begin
              r_digest  <= i_core_H_out;
              r_m_valid <= 1'b1;
              r_state   <= ST_OUT;
            end else begin
              r_s_ready <= 1'b1;
              r_state   <= ST_CHAIN;
            end
          end else if (w_wdog_nxt == WDOG_TC) begin
            r_fault <= 1'b1;
            r_state <= ST_FAULT;
          end
        end
        ST_CHAIN: begin
          if (w_accept) begin
            r_block      <= i_s_block;
            r_last       <= i_s_last;
            r_s_ready    <= 1'b0;
            r_core_start <= 1'b1;
            r_state      <= ST_START;
          end
        end
        ST_OUT: begin
          if (i_m_ready) begin
            r_m_valid <= 1'b0;
            r_chain   <= H_INIT;
            r_s_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        ST_FAULT: begin
          r_s_ready    <= 1'b0;
          r_m_valid    <= 1'b0;
          r_core_start <= 1'b0;
          r_fault      <= 1'b1;
        end
        default: begin
          r_fault <= 1'b1;
          r_state <= ST_FAULT;
        end
      endcase
    end
  end

  assign o_s_ready     = r_s_ready;
  assign o_m_valid     = r_m_valid;
  assign o_m_digest    = r_digest;
  assign o_core_H_in   = r_chain;
  assign o_core_M_in   = r_block;
  assign o_core_start  = r_core_start;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_fault       = r_fault;
  assign o_blocks_done = r_blocks_done;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Bench for sha256_msg_ctrl with a behavioural SHA-256 round core attached.
module tb_sha256_msg_ctrl;

  localparam int COUNT_W  = 32;
  localparam int WDOG_MAX = 80;
  localparam int LAT      = 67;

  localparam logic [255:0] EXP_H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_2B =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_2B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_2B2 = {448'h0, 32'h0, 32'h000001c0};

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = h[255:224]; b = h[223:192]; c = h[191:160]; d = h[159:128];
    e = h[127:96];  f = h[95:64];   g = h[63:32];   hh = h[31:0];
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e,  h[95:64] + f,   h[63:32] + g,   h[31:0] + hh};
  endfunction

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [511:0]       s_block = '0;
  logic               s_last = 1'b0;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic [255:0]       m_digest;
  logic [255:0]       core_H_in;
  logic [511:0]       core_M_in;
  logic               core_start;
  logic [255:0]       core_H_out;
  logic               core_done;
  logic               busy;
  logic               fault;
  logic [COUNT_W-1:0] blocks_done;

  logic               stub = 1'b0;
  logic               spur = 1'b0;
  logic [6:0]         core_cnt;
  logic [255:0]       core_res;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [255:0]       dig;
    logic [COUNT_W-1:0] nblk;
    int                 lat;
  } exp_t;
  exp_t sb[$];

  sha256_msg_ctrl #(.COUNT_W(COUNT_W), .WDOG_MAX(WDOG_MAX)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_block(s_block), .i_s_last(s_last),
    .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_digest(m_digest),
    .o_core_H_in(core_H_in), .o_core_M_in(core_M_in), .o_core_start(core_start),
    .i_core_H_out(core_H_out), .i_core_done(core_done),
    .o_busy(busy), .o_fault(fault), .o_blocks_done(blocks_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: load on start, done pulse 65 cycles later.
  always @(posedge clk) begin
    if (rst) begin
      core_cnt <= '0;
      core_res <= '0;
    end else if (core_start) begin
      core_res <= compress(core_H_in, core_M_in);
      core_cnt <= 7'd1;
    end else if (core_cnt == 7'd65) begin
      core_cnt <= '0;
    end else if (core_cnt != 7'd0) begin
      core_cnt <= core_cnt + 7'd1;
    end
  end
  assign core_done  = ((core_cnt == 7'd65) && !stub) || spur;
  assign core_H_out = spur ? {8{32'hdeadbeef}} : core_res;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [511:0] blk, input logic last, output int t_acc);
    int n;
    n = 0;
    t_acc = -1;
    s_valid = 1'b1; s_block = blk; s_last = last;
    while (t_acc < 0 && n < 200) begin
      if (s_ready) t_acc = cyc;
      tick();
      n++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    n_checks++;
    if (t_acc < 0) begin
      n_fail++;
      $display("FAIL send_accept: s_ready never seen in 200 cycles");
    end
  endtask

  // Scoreboard consumer: wait for the digest and compare with the oldest entry.
  task automatic drain_digest(input int t_acc, input string nm);
    exp_t e;
    int n;
    n = 0;
    while (!m_valid && n < 400) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    n_checks++;
    if (!m_valid) begin
      n_fail++;
      $display("FAIL %s_timeout: m_valid not seen within 400 cycles", nm);
    end else begin
      n_checks += 3;
      if (cyc - t_acc !== e.lat) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d want %0d", nm, cyc - t_acc, e.lat);
      end
      if (m_digest !== e.dig) begin
        n_fail++;
        $display("FAIL %s_digest: got %h want %h", nm, m_digest, e.dig);
      end
      if (blocks_done !== e.nblk) begin
        n_fail++;
        $display("FAIL %s_blocks_done: got %0d want %0d", nm, blocks_done, e.nblk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks += 4;
    if ({s_ready, m_valid, core_start, fault, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy/mv/start/fault/busy=%b want 00000",
               {s_ready, m_valid, core_start, fault, busy});
    end
    if (m_digest !== 256'h0) begin
      n_fail++;
      $display("FAIL reset_digest: got %h want 0", m_digest);
    end
    if (core_H_in !== EXP_H_INIT) begin
      n_fail++;
      $display("FAIL reset_H_in: got %h want %h", core_H_in, EXP_H_INIT);
    end
    if (blocks_done !== '0) begin
      n_fail++;
      $display("FAIL reset_blocks_done: got %0d want 0", blocks_done);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after: got %b want 1", s_ready);
    end
  endtask

  task automatic test_abc();
    int t;
    m_ready = 1'b1;
    sb.push_back('{DIG_ABC, COUNT_W'(1), LAT});
    send_block(BLK_ABC, 1'b1, t);
    n_checks += 3;
    if (core_start !== 1'b1 || core_M_in !== BLK_ABC) begin
      n_fail++;
      $display("FAIL abc_start: got start=%b M=%h want start=1 M=%h", core_start, core_M_in, BLK_ABC);
    end
    if (core_H_in !== EXP_H_INIT || busy !== 1'b1 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abc_start_state: got H=%h busy=%b rdy=%b want H_INIT busy=1 rdy=0",
               core_H_in, busy, s_ready);
    end
    tick();
    if (core_start !== 1'b0) begin
      n_fail++;
      $display("FAIL abc_start_pulse: got start=%b want 0 one cycle later", core_start);
    end
    drain_digest(t, "abc");
    tick();
    n_checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0 || core_H_in !== EXP_H_INIT) begin
      n_fail++;
      $display("FAIL abc_after: got mv=%b rdy=%b busy=%b H=%h want 0 1 0 H_INIT",
               m_valid, s_ready, busy, core_H_in);
    end
  endtask

  task automatic test_two_block();
    int t1, t2, n;
    logic [255:0] mid;
    mid = compress(EXP_H_INIT, BLK_2B1);
    m_ready = 1'b1;
    sb.push_back('{DIG_2B, COUNT_W'(2), 2 * LAT});
    send_block(BLK_2B1, 1'b0, t1);
    n = 0;
    while (!s_ready && n < 200) begin tick(); n++; end
    n_checks += 3;
    if (cyc - t1 !== LAT) begin
      n_fail++;
      $display("FAIL two_chain_latency: got %0d want %0d", cyc - t1, LAT);
    end
    if (blocks_done !== COUNT_W'(1) || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL two_chain_state: got blocks=%0d mv=%b want 1 0", blocks_done, m_valid);
    end
    if (core_H_in !== mid) begin
      n_fail++;
      $display("FAIL two_chain_H_in: got %h want %h", core_H_in, mid);
    end
    send_block(BLK_2B2, 1'b1, t2);
    drain_digest(t1, "two_block");
    tick();
  endtask

  task automatic test_back_to_back();
    int t, held_bad;
    m_ready = 1'b0;
    sb.push_back('{DIG_ABC, COUNT_W'(1), LAT});
    send_block(BLK_ABC, 1'b1, t);
    drain_digest(t, "b2b_first");
    held_bad = 0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_digest !== DIG_ABC || s_ready !== 1'b0) begin
        n_fail++;
        held_bad++;
        $display("FAIL b2b_hold: cycle %0d got mv=%b rdy=%b dig=%h want 1 0 %h",
                 i, m_valid, s_ready, m_digest, DIG_ABC);
      end
      tick();
    end
    m_ready = 1'b1;
    tick();
    n_checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_release: got rdy=%b mv=%b want 1 0", s_ready, m_valid);
    end
    sb.push_back('{DIG_ABC, COUNT_W'(1), LAT});
    send_block(BLK_ABC, 1'b1, t);
    drain_digest(t, "b2b_second");
    tick();
  endtask

  task automatic test_spurious();
    int t1, t2, n;
    logic [255:0] mid;
    mid = compress(EXP_H_INIT, BLK_2B1);
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    n_checks += 2;
    if (busy !== 1'b0 || s_ready !== 1'b1 || m_valid !== 1'b0 || blocks_done !== COUNT_W'(1)) begin
      n_fail++;
      $display("FAIL spur_idle_state: got busy=%b rdy=%b mv=%b blocks=%0d want 0 1 0 1",
               busy, s_ready, m_valid, blocks_done);
    end
    if (core_H_in !== EXP_H_INIT || m_digest !== DIG_ABC) begin
      n_fail++;
      $display("FAIL spur_idle_data: got H=%h dig=%h want H_INIT %h", core_H_in, m_digest, DIG_ABC);
    end
    m_ready = 1'b1;
    send_block(BLK_2B1, 1'b0, t1);
    n = 0;
    while (!s_ready && n < 200) begin tick(); n++; end
    spur = 1'b1;
    tick(); tick(); tick();
    spur = 1'b0;
    n_checks++;
    if (blocks_done !== COUNT_W'(1) || core_H_in !== mid || s_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL spur_chain: got blocks=%0d rdy=%b busy=%b H=%h want 1 1 1 %h",
               blocks_done, s_ready, busy, core_H_in, mid);
    end
    sb.push_back('{DIG_2B, COUNT_W'(2), LAT});
    send_block(BLK_2B2, 1'b1, t2);
    drain_digest(t2, "spur_two_block");
    tick();
  endtask

  task automatic test_rst_mid();
    int t;
    m_ready = 1'b1;
    send_block(BLK_2B1, 1'b0, t);
    repeat (30) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_busy_before: got %b want 1", busy);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({s_ready, m_valid, core_start, fault, busy} !== 5'b0 || blocks_done !== '0 ||
        core_H_in !== EXP_H_INIT || m_digest !== 256'h0) begin
      n_fail++;
      $display("FAIL rstmid_values: got rdy/mv/start/fault/busy=%b blocks=%0d H=%h dig=%h",
               {s_ready, m_valid, core_start, fault, busy}, blocks_done, core_H_in, m_digest);
    end
    rst = 1'b0;
    tick();
    sb.push_back('{DIG_ABC, COUNT_W'(1), LAT});
    send_block(BLK_ABC, 1'b1, t);
    drain_digest(t, "rstmid_abc");
    tick();
  endtask

  task automatic test_fault();
    int t, n;
    stub = 1'b1;
    m_ready = 1'b1;
    send_block(BLK_ABC, 1'b1, t);
    n = 0;
    while (!fault && n < 200) begin tick(); n++; end
    n_checks += 2;
    if (!fault) begin
      n_fail++;
      $display("FAIL fault_timeout: fault not seen within 200 cycles");
    end else if (cyc - t !== 2 + WDOG_MAX) begin
      n_fail++;
      $display("FAIL fault_cycle: got accept+%0d want accept+%0d", cyc - t, 2 + WDOG_MAX);
    end
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || core_start !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_outputs: got rdy=%b mv=%b start=%b busy=%b want 0 0 0 1",
               s_ready, m_valid, core_start, busy);
    end
    stub = 1'b0;
    s_valid = 1'b1; s_block = BLK_ABC; s_last = 1'b1;
    spur = 1'b1;
    repeat (5) tick();
    spur = 1'b0;
    n_checks++;
    if (fault !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_sticky: got fault=%b rdy=%b mv=%b want 1 0 0", fault, s_ready, m_valid);
    end
    s_valid = 1'b0; s_last = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (fault !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_cleared: got fault=%b rdy=%b busy=%b want 0 1 0", fault, s_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_two_block();
    test_back_to_back();
    test_spurious();
    test_rst_mid();
    test_fault();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
